axi_sram_bridge: RTL and testbench
==================================

# axi_sram_bridge

Converts the core's two SRAM-like ports (instruction fetch, data load/store) into a single AXI3 master with 32-bit data and single-beat transfers. Sits directly downstream of the five-stage core, between its memory ports and the SoC crossbar, inside the top-level CPU wrapper. Arbitrates reads, tracks one outstanding read and one outstanding write, and blocks read-after-write hazards on the data side.

## Interface

Parameters:
- `ADDR_W`, default 32: address width on both sides.
- `ID_INST`, default 4'd0: AXI ID for instruction reads.
- `ID_DATA`, default 4'd1: AXI ID for data reads and writes.

Ports:
- `clk`: in, 1, sole clock.
- `rst`: in, 1, asynchronous, active-high reset.
- `inst_req`, `inst_addr[31:0]`: in, instruction read request.
- `inst_addr_ok`, `inst_data_ok`: out, 1 each, accept and return pulses.
- `inst_rdata`: out, 32, fetched word.
- `data_req`, `data_wr`: in, 1 each, request and write flag.
- `data_size`: in, 2, byte/half/word (0/1/2).
- `data_addr`, `data_wdata`: in, 32 each.
- `data_wstrb`: in, 4, byte enables.
- `data_addr_ok`, `data_data_ok`: out, 1 each.
- `data_rdata`: out, 32.
- AR channel: out `arid[3:0]`, `araddr[31:0]`, `arsize[2:0]`, `arvalid`; in `arready`.
- R channel: in `rid[3:0]`, `rdata[31:0]`, `rvalid`; out `rready`.
- AW/W channel: out `awaddr[31:0]`, `awsize[2:0]`, `awvalid`, `wdata[31:0]`, `wstrb[3:0]`, `wvalid`; in `awready`, `wready`.
- B channel: in `bvalid`; out `bready`.
- Constant outputs: `awid = ID_DATA`, `wid = ID_DATA`, `arlen = awlen = 0`, `arburst = awburst = 2'b01`, `wlast = 1`, lock, cache and prot all 0.

## Operation

- Read FSM states: R_IDLE, R_AR, R_R.
  - R_IDLE → R_AR on an accepted read. A data read has priority over an instruction read in the same cycle.
  - R_AR → R_R on `arvalid & arready`.
  - R_R → R_IDLE on `rvalid & rready`.
- Write FSM states: W_IDLE, W_AW_W, W_B.
  - W_IDLE → W_AW_W on an accepted data write.
  - In W_AW_W, AW and W complete independently. Each has its own done flag, and `awvalid`/`wvalid` drop individually on their own handshake.
  - W_AW_W → W_B once both are done. W_B → W_IDLE on `bvalid`.
- `data_addr_ok` is combinational:
  - For a write: `data_req & data_wr` & write FSM in W_IDLE.
  - For a read: `data_req & ~data_wr` & read FSM in R_IDLE & no RAW block.
- `inst_addr_ok` is asserted when `inst_req` & R_IDLE & the data port is not winning the read slot this cycle.
- Address, size, wdata and wstrb are latched on accept. `arsize`/`awsize` equal `{1'b0, size}`. `araddr` is passed through unaligned as given.
- Return routing:
  - On the R handshake, `rid == ID_INST` pulses `inst_data_ok` and `rid == ID_DATA` pulses `data_data_ok`, each for exactly one cycle.
  - `inst_rdata` and `data_rdata` show `rdata` in that cycle.
  - A completed write pulses `data_data_ok` on the `bvalid` cycle.
- If a read return and a write response land in the same cycle, the read's `data_data_ok` is pulsed that cycle and the write's is pulsed the next cycle. A 1-entry pending flag holds the deferred pulse.

## Timing

- All valids are registered. `arvalid` rises one cycle after `addr_ok` and holds until `arready`. The same applies to `awvalid` and `wvalid`.
- `rready` = (state == R_R). `bready` = (state == W_B).
- Minimum read latency: accept at cycle 0, AR handshake at cycle 1, `data_ok` at cycle 2 if the slave responds immediately.
- Minimum write latency: accept at 0, AW/W at 1, B at 2.
- Reset values: every valid, ready, `*_addr_ok` and `*_data_ok` is 0; both FSMs are in IDLE; all latched addresses and data are 0; the deferred flag is clear.
- Reset asserted mid-transaction returns to IDLE immediately. Any AXI response after reset is ignored: `rready`/`bready` are 0.

## Configuration

- `BRIDGE_RAW_ADDR_CHECK_EN` defined: a data read is blocked only while a write is in flight to the same word, i.e. `data_addr[31:2] == awaddr[31:2]`.
- Undefined: any data read is blocked while the write FSM is not in W_IDLE.
- Instruction reads are never RAW-blocked in either mode.

## Structure

- Shared package `bridge_pkg`:
  - FSM state encodings `R_IDLE`/`R_AR`/`R_R` and `W_IDLE`/`W_AW_W`/`W_B`.
  - `ID_INST`/`ID_DATA` defaults.
  - The size-to-`axsize` mapping function.
- One sub-module, `bridge_rd_arb`: fixed-priority data-over-instruction read arbiter producing the grant and both read `addr_ok` signals.

## Test plan

- Instruction read of 0xBFC00000 with `arready`/`rvalid` immediately high, rdata 0x3C1D8000 → `inst_addr_ok` at cycle 0, `arvalid` at cycle 1, `inst_data_ok` pulse with 0x3C1D8000 at cycle 2.
- Simultaneous `inst_req` and data read of 0x80001000 → data granted, `arid = 1`; instruction accepted only after the data `data_ok`.
- Data write of 0x12345678, wstrb 4'b0011, with `wready` delayed 3 cycles after `awready` → `awvalid` drops at its own handshake, `wvalid` holds until `wready`, one `data_data_ok` on `bvalid`.
- Write to 0x80000010 pending, then a read of 0x80000010 → read not accepted until `bvalid`. With the macro defined, a read of 0x80000020 is accepted at once.
- Read return and B response in the same cycle → read `data_data_ok` that cycle, write `data_data_ok` the next cycle, never merged.
- `rst` asserted while in R_R → all outputs 0 in the same cycle, and a late `rvalid` produces no `data_ok`.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared FSM encodings, default AXI IDs and the size-to-axsize mapping
// used by the SRAM-to-AXI3 bridge.
package bridge_pkg;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_AW_W, W_B} wr_state_e;

    localparam logic [3:0] ID_INST_DEF = 4'd0;
    localparam logic [3:0] ID_DATA_DEF = 4'd1;

    function automatic logic [2:0] size_to_axsize(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/bridge_rd_arb.sv
// Fixed-priority read-slot arbiter: a data read beats an instruction fetch
// whenever both are presented while the read channel is idle.
module bridge_rd_arb (
    input  logic inst_req_i,
    input  logic data_rd_req_i,
    input  logic rd_idle_i,
    output logic grant_data_o,
    output logic inst_addr_ok_o,
    output logic data_addr_ok_o
);

    always_comb begin
        grant_data_o   = rd_idle_i & data_rd_req_i;
        data_addr_ok_o = grant_data_o;
        inst_addr_ok_o = rd_idle_i & inst_req_i & ~data_rd_req_i;
    end

endmodule

// File: rtl/axi_sram_bridge.sv
// Core SRAM-like inst/data ports to a single-beat AXI3 master; one read and one write in flight.
// Define BRIDGE_RAW_ADDR_CHECK_EN to block data reads only on a same-word write in flight.
module axi_sram_bridge
    import bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter logic [3:0]  ID_INST = ID_INST_DEF,
    parameter logic [3:0]  ID_DATA = ID_DATA_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [3:0]        data_wstrb,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [31:0]       rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [3:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [3:0]        wid,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    rd_state_e         r_state_q, r_state_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic [2:0]        ar_size_q, ar_size_d;
    logic [3:0]        ar_id_q, ar_id_d;

    wr_state_e         w_state_q, w_state_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [2:0]        aw_size_q, aw_size_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;

    logic pend_q, pend_d;
    logic raw_block, data_rd_req, grant_data, data_rd_addr_ok, wr_accept;
    logic aw_hs, w_hs, r_hs, b_hs, rd_data_ok, wr_ok_evt;

`ifdef BRIDGE_RAW_ADDR_CHECK_EN
    assign raw_block = (w_state_q != W_IDLE) &&
                       (data_addr[ADDR_W-1:2] == aw_addr_q[ADDR_W-1:2]);
`else
    assign raw_block = (w_state_q != W_IDLE);
`endif

    assign data_rd_req  = data_req & ~data_wr & ~raw_block;
    assign wr_accept    = data_req & data_wr & (w_state_q == W_IDLE);
    assign data_addr_ok = wr_accept | data_rd_addr_ok;

    bridge_rd_arb u_rd_arb (
        .inst_req_i     (inst_req),
        .data_rd_req_i  (data_rd_req),
        .rd_idle_i      (r_state_q == R_IDLE),
        .grant_data_o   (grant_data),
        .inst_addr_ok_o (inst_addr_ok),
        .data_addr_ok_o (data_rd_addr_ok)
    );

    always_comb begin
        r_state_d = r_state_q;
        arvalid_d = arvalid_q;
        ar_addr_d = ar_addr_q;
        ar_size_d = ar_size_q;
        ar_id_d   = ar_id_q;
        case (r_state_q)
            R_IDLE: begin
                if (grant_data) begin
                    r_state_d = R_AR;
                    arvalid_d = 1'b1;
                    ar_addr_d = data_addr;
                    ar_size_d = size_to_axsize(data_size);
                    ar_id_d   = ID_DATA;
                end else if (inst_addr_ok) begin
                    r_state_d = R_AR;
                    arvalid_d = 1'b1;
                    ar_addr_d = inst_addr;
                    ar_size_d = size_to_axsize(2'd2);
                    ar_id_d   = ID_INST;
                end
            end
            R_AR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    r_state_d = R_R;
                end
            end
            R_R: begin
                if (rvalid) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign aw_hs = awvalid_q & awready;
    assign w_hs  = wvalid_q & wready;

    always_comb begin
        w_state_d = w_state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        aw_addr_d = aw_addr_q;
        aw_size_d = aw_size_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        case (w_state_q)
            W_IDLE: begin
                if (wr_accept) begin
                    w_state_d = W_AW_W;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    aw_addr_d = data_addr;
                    aw_size_d = size_to_axsize(data_size);
                    wdata_d   = data_wdata;
                    wstrb_d   = data_wstrb;
                end
            end
            W_AW_W: begin
                // AW and W retire independently; move on once both have.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) w_state_d = W_B;
            end
            W_B: begin
                if (bvalid) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign rready       = (r_state_q == R_R);
    assign bready       = (w_state_q == W_B);
    assign r_hs         = rready & rvalid;
    assign b_hs         = bready & bvalid;
    assign inst_data_ok = r_hs & (rid == ID_INST);
    assign rd_data_ok   = r_hs & (rid == ID_DATA);
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    // A write response colliding with a data read return is replayed next cycle.
    assign wr_ok_evt    = b_hs | pend_q;
    assign data_data_ok = rd_data_ok | wr_ok_evt;
    assign pend_d       = rd_data_ok & wr_ok_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            arvalid_q <= 1'b0;
            ar_addr_q <= '0;
            ar_size_q <= '0;
            ar_id_q   <= '0;
            w_state_q <= W_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            aw_addr_q <= '0;
            aw_size_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            pend_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arvalid_q <= arvalid_d;
            ar_addr_q <= ar_addr_d;
            ar_size_q <= ar_size_d;
            ar_id_q   <= ar_id_d;
            w_state_q <= w_state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            aw_addr_q <= aw_addr_d;
            aw_size_q <= aw_size_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            pend_q    <= pend_d;
        end
    end

    assign arid    = ar_id_q;
    assign araddr  = ar_addr_q;
    assign arsize  = ar_size_q;
    assign arvalid = arvalid_q;
    assign awaddr  = aw_addr_q;
    assign awsize  = aw_size_q;
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wvalid  = wvalid_q;

    assign awid    = ID_DATA;
    assign wid     = ID_DATA;
    assign arlen   = 4'd0;
    assign awlen   = 4'd0;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign wlast   = 1'b1;
    assign arlock  = 2'b00;
    assign awlock  = 2'b00;
    assign arcache = 4'd0;
    assign awcache = 4'd0;
    assign arprot  = 3'd0;
    assign awprot  = 3'd0;

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Randomized scoreboard bench for axi_sram_bridge: a random requester and AXI slave,
// a transaction-level model of what must be accepted, issued and returned.
module tb_axi_sram_bridge;

    localparam logic [3:0] IDI = 4'd0;
    localparam logic [3:0] IDD = 4'd1;

    logic clk = 1'b0;
    logic rst;
    logic inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0] data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0] data_wstrb;
    logic [3:0] arid, arlen, arcache, rid, awid, awlen, awcache, wid, wstrb;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0] arsize, arprot, awsize, awprot;
    logic [1:0] arburst, arlock, awburst, awlock;
    logic arvalid, arready, rvalid, rready, awvalid, awready;
    logic wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    axi_sram_bridge dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready), .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {logic [31:0] addr; logic [3:0] id; logic [2:0] size;} ar_t;
    typedef struct packed {logic [31:0] addr; logic [2:0] size;} aw_t;
    typedef struct packed {logic [31:0] data; logic [3:0] strb;} w_t;

    ar_t exp_ar_q[$];
    aw_t exp_aw_q[$];
    w_t  exp_w_q[$];
    logic [31:0] exp_inst_q[$];
    logic [31:0] exp_rd_q[$];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit mon_en = 1'b0;

    // Transaction-level view of what is outstanding on each side.
    bit m_rd_busy, m_ar_out, m_wr_busy, m_aw_out, m_w_out, m_carry;
    logic [31:0] m_wr_addr;
    // Handshakes seen at the last negedge, consumed by the driver.
    bit ar_hs_f, r_hs_f, aw_hs_f, w_hs_f, b_hs_f, inst_acc_f, data_acc_f;
    logic [31:0] cap_araddr;
    logic [3:0] cap_arid;
    // Slave state.
    bit sl_r_pend, sl_aw, sl_w;
    logic [31:0] sl_r_addr;
    logic [3:0] sl_r_id;
    int unsigned sl_r_dly, sl_b_dly;

    bit raw, e_dok, e_iok, ar_hs, aw_hs, w_hs, r_hs, b_hs, r_inst, r_data, e_wr;
    ar_t a_e;
    aw_t aw_e;
    w_t w_e;
    logic [31:0] d_e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic empty_pop(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: DUT output with nothing expected (t=%0t)", name, $time);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
`ifdef BRIDGE_RAW_ADDR_CHECK_EN
            raw = m_wr_busy && (data_addr[31:2] == m_wr_addr[31:2]);
`else
            raw = m_wr_busy;
`endif
            e_dok = data_req && (data_wr ? !m_wr_busy : (!m_rd_busy && !raw));
            e_iok = inst_req && !m_rd_busy && !(data_req && !data_wr && !raw);
            check("data_addr_ok", 32'(data_addr_ok), 32'(e_dok));
            check("inst_addr_ok", 32'(inst_addr_ok), 32'(e_iok));
            check("arvalid", 32'(arvalid), 32'(m_ar_out));
            check("awvalid", 32'(awvalid), 32'(m_aw_out));
            check("wvalid", 32'(wvalid), 32'(m_w_out));
            check("rready", 32'(rready), 32'(m_rd_busy && !m_ar_out));
            check("bready", 32'(bready), 32'(m_wr_busy && !m_aw_out && !m_w_out));

            ar_hs = arvalid && arready;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            r_hs  = rvalid && rready;
            b_hs  = bvalid && bready;
            r_inst = r_hs && (rid == IDI);
            r_data = r_hs && (rid == IDD);

            if (ar_hs) begin
                if (exp_ar_q.size() == 0) empty_pop("ar_handshake");
                else begin
                    a_e = exp_ar_q.pop_front();
                    check("araddr", araddr, a_e.addr);
                    check("arid", 32'(arid), 32'(a_e.id));
                    check("arsize", 32'(arsize), 32'(a_e.size));
                end
                m_ar_out = 1'b0;
                cap_araddr = araddr;
                cap_arid = arid;
            end
            if (aw_hs) begin
                if (exp_aw_q.size() == 0) empty_pop("aw_handshake");
                else begin
                    aw_e = exp_aw_q.pop_front();
                    check("awaddr", awaddr, aw_e.addr);
                    check("awsize", 32'(awsize), 32'(aw_e.size));
                end
                m_aw_out = 1'b0;
            end
            if (w_hs) begin
                if (exp_w_q.size() == 0) empty_pop("w_handshake");
                else begin
                    w_e = exp_w_q.pop_front();
                    check("wdata", wdata, w_e.data);
                    check("wstrb", 32'(wstrb), 32'(w_e.strb));
                end
                m_w_out = 1'b0;
            end

            check("inst_data_ok", 32'(inst_data_ok), 32'(r_inst));
            if (inst_data_ok) begin
                if (exp_inst_q.size() == 0) empty_pop("inst_data_ok");
                else check("inst_rdata", inst_rdata, exp_inst_q.pop_front());
            end
            if (r_data) begin
                if (exp_rd_q.size() == 0) empty_pop("data_read_return");
                else check("data_rdata", data_rdata, exp_rd_q.pop_front());
            end
            // A write response yields way to a same-cycle data read return.
            e_wr = (b_hs && !r_data) || m_carry;
            m_carry = b_hs && r_data;
            check("data_data_ok", 32'(data_data_ok), 32'(r_data || e_wr));
            if (r_hs) m_rd_busy = 1'b0;
            if (b_hs) m_wr_busy = 1'b0;

            if (e_iok) begin
                a_e = '{addr: inst_addr, id: IDI, size: 3'd2};
                exp_ar_q.push_back(a_e);
                exp_inst_q.push_back(mem_word(inst_addr));
                m_rd_busy = 1'b1;
                m_ar_out = 1'b1;
            end
            if (e_dok && data_wr) begin
                aw_e = '{addr: data_addr, size: {1'b0, data_size}};
                w_e = '{data: data_wdata, strb: data_wstrb};
                exp_aw_q.push_back(aw_e);
                exp_w_q.push_back(w_e);
                m_wr_busy = 1'b1;
                m_aw_out = 1'b1;
                m_w_out = 1'b1;
                m_wr_addr = data_addr;
            end else if (e_dok) begin
                a_e = '{addr: data_addr, id: IDD, size: {1'b0, data_size}};
                exp_ar_q.push_back(a_e);
                exp_rd_q.push_back(mem_word(data_addr));
                m_rd_busy = 1'b1;
                m_ar_out = 1'b1;
            end

            ar_hs_f = ar_hs;
            r_hs_f = r_hs;
            aw_hs_f = aw_hs;
            w_hs_f = w_hs;
            b_hs_f = b_hs;
            inst_acc_f = e_iok;
            data_acc_f = e_dok;
        end
    end

    task automatic drive_cycle(input bit allow_new);
        if (!allow_new) begin
            inst_req = 1'b0;
            data_req = 1'b0;
        end else begin
            if (inst_acc_f || !inst_req) begin
                inst_req = ($urandom_range(0, 2) == 0);
                inst_addr = 32'hBFC0_0000 + (32'($urandom_range(0, 63)) << 2);
            end
            if (data_acc_f || !data_req) begin
                data_req = ($urandom_range(0, 1) == 0);
                data_wr = 1'($urandom_range(0, 1));
                data_size = 2'($urandom_range(0, 2));
                data_addr = 32'h8000_0000 + (32'($urandom_range(0, 7)) << 2)
                          + 32'($urandom_range(0, 3));
                data_wdata = $urandom;
                data_wstrb = 4'($urandom_range(1, 15));
            end
        end
        arready = 1'($urandom_range(0, 1));
        awready = 1'($urandom_range(0, 1));
        wready = 1'($urandom_range(0, 1));
        if (r_hs_f) begin
            rvalid = 1'b0;
            sl_r_pend = 1'b0;
        end
        if (ar_hs_f) begin
            sl_r_pend = 1'b1;
            sl_r_addr = cap_araddr;
            sl_r_id = cap_arid;
            sl_r_dly = $urandom_range(0, 3);
        end
        if (sl_r_pend && !rvalid) begin
            if (sl_r_dly == 0) begin
                rvalid = 1'b1;
                rid = sl_r_id;
                rdata = mem_word(sl_r_addr);
            end else sl_r_dly--;
        end
        if (b_hs_f) begin
            bvalid = 1'b0;
            sl_aw = 1'b0;
            sl_w = 1'b0;
        end
        if (aw_hs_f) begin
            sl_aw = 1'b1;
            sl_b_dly = $urandom_range(0, 3);
        end
        if (w_hs_f) sl_w = 1'b1;
        if (sl_aw && sl_w && !bvalid) begin
            if (sl_b_dly == 0) bvalid = 1'b1;
            else sl_b_dly--;
        end
    endtask

    initial begin
        rst = 1'b1;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0;
        data_wdata = '0; data_wstrb = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b1; rid = IDD; rdata = '0; bvalid = 1'b1;

        // Reset: responses presented during reset must be ignored.
        @(negedge clk);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_awvalid", 32'(awvalid), 32'd0);
        check("rst_wvalid", 32'(wvalid), 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_bready", 32'(bready), 32'd0);
        check("rst_data_data_ok", 32'(data_data_ok), 32'd0);
        check("rst_araddr", araddr, 32'd0);
        check("rst_awaddr", awaddr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        rvalid = 1'b0;
        bvalid = 1'b0;
        rst = 1'b0;

        // Back-to-back instruction fetch with an always-ready slave.
        @(posedge clk); #1;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        arready = 1'b1; rvalid = 1'b1; rid = IDI; rdata = 32'h3C1D_8000;
        @(negedge clk);
        check("lat_c0_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        check("lat_c0_arvalid", 32'(arvalid), 32'd0);
        @(posedge clk); #1;
        inst_req = 1'b0;
        @(negedge clk);
        check("lat_c1_arvalid", 32'(arvalid), 32'd1);
        check("lat_c1_araddr", araddr, 32'hBFC0_0000);
        check("lat_c1_arsize", 32'(arsize), 32'd2);
        check("lat_c1_inst_data_ok", 32'(inst_data_ok), 32'd0);
        @(negedge clk);
        check("lat_c2_inst_data_ok", 32'(inst_data_ok), 32'd1);
        check("lat_c2_inst_rdata", inst_rdata, 32'h3C1D_8000);
        @(posedge clk); #1;
        rvalid = 1'b0; arready = 1'b0;
        @(negedge clk);
        check("lat_c3_inst_data_ok", 32'(inst_data_ok), 32'd0);
        check("lat_c3_rready", 32'(rready), 32'd0);

        // Randomized traffic against the transaction model.
        mon_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            drive_cycle(1'b1);
        end
        for (int i = 0; i < 200 && (m_rd_busy || m_wr_busy || m_carry); i++) begin
            @(posedge clk); #1;
            drive_cycle(1'b0);
        end
        check("drain_idle", 32'(m_rd_busy || m_wr_busy || m_carry), 32'd0);
        check("drain_inst_q", exp_inst_q.size(), 32'd0);
        check("drain_rd_q", exp_rd_q.size(), 32'd0);
        @(posedge clk); #1;
        mon_en = 1'b0;

        // Reset while a read is waiting on its response.
        rvalid = 1'b0; bvalid = 1'b0; arready = 1'b1;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0040;
        @(posedge clk); #1;
        inst_req = 1'b0;
        @(posedge clk); #1;
        check("rr_rready_before_rst", 32'(rready), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rr_rst_rready", 32'(rready), 32'd0);
        check("rr_rst_arvalid", 32'(arvalid), 32'd0);
        check("rr_rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        rvalid = 1'b1; rid = IDI; rdata = 32'hDEAD_BEEF;
        #1;
        check("rr_rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rr_late_inst_data_ok", 32'(inst_data_ok), 32'd0);
            check("rr_late_data_data_ok", 32'(data_data_ok), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
